// File: rtl/mux_pkg.sv
// Shared constants and scan FSM encoding for the 8:1 mux and its scan controller.
package mux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SETTLE_WAIT = 2'd1,
        ST_SAMPLE      = 2'd2,
        ST_DONE        = 2'd3
    } scan_state_t;

    // Lowest set index of a channel mask; returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_8x1_scan_ctrl_if.sv
// Handshake and data bundle between a scan master and the mux scan controller.
interface mux_8x1_scan_ctrl_if;

    logic                         start;
    logic [mux_pkg::NUM_CH-1:0]   mask;
    logic                         y;
    logic [mux_pkg::SEL_W-1:0]    s;
    logic                         busy;
    logic                         done;
    logic [mux_pkg::NUM_CH-1:0]   data;
    logic                         changed;

    modport slave (
        input  start,
        input  mask,
        input  y,
        output s,
        output busy,
        output done,
        output data,
        output changed
    );

    modport master (
        output start,
        output mask,
        output y,
        input  s,
        input  busy,
        input  done,
        input  data,
        input  changed
    );

endinterface

// File: rtl/mux_8x1_st.sv
// Plain combinational 8:1 mux whose select is driven by the scan controller.
module mux_8x1_st
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] i_d,
    input  logic [SEL_W-1:0]  i_sel,
    output logic              o_y
);

    assign o_y = i_d[i_sel];

endmodule

// File: rtl/mux_next_sel.sv
// Finds the next set mask bit strictly above the current index.
module mux_next_sel
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_cur,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_valid
);

    always_comb begin
        o_next  = '0;
        o_valid = 1'b0;
        // Scan downwards so the lowest qualifying index wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((i > int'(i_cur)) && i_mask[i]) begin
                o_next  = SEL_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_8x1_scan_ctrl.sv
// Walks the mux select over the masked channels, samples y into a shadow
// register and publishes a snapshot plus a changed flag at the end of a pass.
//
// state          | meaning
// ST_IDLE        | waiting for start with a non-empty mask
// ST_SETTLE_WAIT | select just changed, counting SETTLE cycles
// ST_SAMPLE      | y written into shadow[s] on the closing edge
// ST_DONE        | one-cycle done pulse, snapshot valid
module mux_8x1_scan_ctrl
    import mux_pkg::*;
#(
    parameter int SETTLE = 0
)
(
    input  logic                clk,
    input  logic                rst,
    mux_8x1_scan_ctrl_if.slave  bus
);

    localparam bit         HAS_SETTLE = (SETTLE > 0);
    localparam logic [1:0] SETTLE_LD  = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [NUM_CH-1:0]  r_mask_lat;
    logic [SEL_W-1:0]   r_s;
    logic [1:0]         r_cnt;
    logic [NUM_CH-1:0]  r_shadow;
    logic [NUM_CH-1:0]  r_data;
    logic               r_changed;

    logic               w_start_ok;
    logic [SEL_W-1:0]   w_next_s;
    logic               w_next_vld;
    logic [NUM_CH-1:0]  w_shadow_smp;
    logic               w_busy;
    logic               w_done;

    assign w_start_ok = bus.start && (bus.mask != '0);

    mux_next_sel u_next_sel (
        .i_mask  (r_mask_lat),
        .i_cur   (r_s),
        .o_next  (w_next_s),
        .o_valid (w_next_vld)
    );

    // Shadow as it will look after the current SAMPLE edge.
    always_comb begin
        w_shadow_smp       = r_shadow;
        w_shadow_smp[r_s]  = bus.y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = HAS_SETTLE ? ST_SETTLE_WAIT : ST_SAMPLE;
                end
            end
            ST_SETTLE_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_next_vld) begin
                    w_state_nxt = HAS_SETTLE ? ST_SETTLE_WAIT : ST_SAMPLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_SETTLE_WAIT: w_busy = 1'b1;
            ST_SAMPLE:      w_busy = 1'b1;
            ST_DONE:        w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask_lat <= '0;
            r_s        <= '0;
            r_cnt      <= 2'd0;
            r_shadow   <= '0;
            r_data     <= '0;
            r_changed  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_mask_lat <= bus.mask;
                        r_s        <= lowest_set(bus.mask);
                        r_cnt      <= SETTLE_LD;
                    end
                end
                ST_SETTLE_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_shadow <= w_shadow_smp;
                    if (w_next_vld) begin
                        r_s   <= w_next_s;
                        r_cnt <= SETTLE_LD;
                    end else begin
                        // Publish on the edge that enters DONE, including this last sample.
                        r_data    <= w_shadow_smp;
                        r_changed <= (w_shadow_smp != r_data);
                    end
                end
                ST_DONE: begin
                    r_s <= '0;
                end
                default: begin
                    r_s <= '0;
                end
            endcase
        end
    end

    assign bus.s       = r_s;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.data    = r_data;
    assign bus.changed = r_changed;

endmodule
